// File: rtl/qam_slicer_packer.sv
// Hard-decision QPSK / Gray-coded 16-QAM slicer that packs decided bits MSB-first
// into OUT_W-bit words behind a registered valid/ready output with flush support.
module qam_slicer_packer #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 8,
  parameter int THRESH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  I_in,
  input  logic signed [DATA_W-1:0]  Q_in,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [$clog2(OUT_W):0]    out_bits
);

  localparam int CNT_W = $clog2(OUT_W);
  localparam int BW    = CNT_W + 1;
  localparam logic [BW-1:0]     OUT_W_V  = BW'(OUT_W);
  localparam logic [DATA_W:0]   THRESH_V = (DATA_W + 1)'(THRESH);

  logic [CNT_W-1:0] cnt_reg;
  logic [OUT_W-1:0] shift_reg;
  logic             mode_reg;
  logic             out_valid_reg;
  logic [OUT_W-1:0] out_data_reg;
  logic [BW-1:0]    out_bits_reg;

  logic [DATA_W-1:0] axis [2];
  logic [1:0]        hi_bit;
  logic [1:0]        lo_bit;

  assign axis[0] = I_in;
  assign axis[1] = Q_in;

  // Magnitude is one bit wider so the most negative sample stays an outer point.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      logic [DATA_W:0] ext;
      logic [DATA_W:0] mag;
      assign ext        = {axis[gi][DATA_W-1], axis[gi]};
      assign mag        = axis[gi][DATA_W-1] ? ({(DATA_W+1){1'b0}} - ext) : ext;
      assign hi_bit[gi] = ~axis[gi][DATA_W-1];
      assign lo_bit[gi] = (mag < THRESH_V);
    end
  endgenerate

  logic             mode_eff;
  logic [3:0]       sym_bits;
  logic [BW-1:0]    nb;
  logic             sym_fire;
  logic [BW-1:0]    cnt_sum;
  logic [OUT_W-1:0] packed_bits;
  logic             word_done;
  logic             flush_fire;
  logic [OUT_W-1:0] flush_data;

  assign in_ready = !out_valid_reg || out_ready;
  assign sym_fire = in_valid && in_ready;

  // Mode is only taken from the port at a word boundary; mid-word it is frozen.
  assign mode_eff = (cnt_reg == '0) ? mode : mode_reg;
  assign sym_bits = mode_eff ? {hi_bit[0], lo_bit[0], hi_bit[1], lo_bit[1]}
                             : {2'b00, hi_bit[0], hi_bit[1]};
  assign nb       = mode_eff ? BW'(4) : BW'(2);

  assign cnt_sum     = {1'b0, cnt_reg} + (sym_fire ? nb : '0);
  assign packed_bits = sym_fire ? ((shift_reg << nb) | OUT_W'(sym_bits)) : shift_reg;
  assign word_done   = sym_fire && (cnt_sum == OUT_W_V);
  assign flush_fire  = flush && in_ready && !word_done && (cnt_sum != '0);
  assign flush_data  = packed_bits << (OUT_W_V - cnt_sum);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg       <= '0;
      shift_reg     <= '0;
      mode_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_bits_reg  <= '0;
    end else begin
      if (sym_fire && cnt_reg == '0)
        mode_reg <= mode;

      if (word_done || flush_fire) begin
        cnt_reg   <= '0;
        shift_reg <= '0;
      end else begin
        cnt_reg   <= cnt_sum[CNT_W-1:0];
        shift_reg <= packed_bits;
      end

      if (word_done) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= packed_bits;
        out_bits_reg  <= OUT_W_V;
      end else if (flush_fire) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= flush_data;
        out_bits_reg  <= cnt_sum;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_bits  = out_bits_reg;

endmodule

// File: tb/tb_qam_slicer_packer.sv
// Directed bench for qam_slicer_packer (DATA_W=16, OUT_W=8, THRESH=2) with
// immediate assertions at every comparison point.
module tb_qam_slicer_packer;

  logic        clk;
  logic        reset;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] I_in;
  logic [15:0] Q_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_bits;

  int checks   = 0;
  int failures = 0;

  localparam logic [15:0] NEG = 16'h8000;
  localparam logic [15:0] POS = 16'h0001;
  localparam logic [15:0] P3  = 16'h0003;
  localparam logic [15:0] P1  = 16'h0001;
  localparam logic [15:0] M1  = 16'hFFFF;
  localparam logic [15:0] M3  = 16'hFFFD;
  localparam logic [15:0] ZER = 16'h0000;

  qam_slicer_packer #(.DATA_W(16), .OUT_W(8), .THRESH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .I_in      (I_in),
    .Q_in      (Q_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bits  (out_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sym(input logic [15:0] i, input logic [15:0] q);
    in_valid = 1'b1;
    I_in     = i;
    Q_in     = q;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b0; mode = 1'b0; in_valid = 1'b0; I_in = '0; Q_in = '0;
    flush = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 8'h00);
    chk("rst_bits",  out_bits, 4'd0);
    reset = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1);

    // QPSK word: 00 10 01 11 -> 0x27
    sym(NEG, NEG); chk("qpsk_s1_valid", out_valid, 0);
    sym(POS, NEG); chk("qpsk_s2_valid", out_valid, 0);
    sym(NEG, POS); chk("qpsk_s3_valid", out_valid, 0);
    sym(POS, POS);
    chk("qpsk_valid", out_valid, 1);
    chk("qpsk_data",  out_data, 8'h27);
    chk("qpsk_bits",  out_bits, 4'd8);
    idle();
    chk("qpsk_1cycle", out_valid, 0);

    // 16-QAM word: (+3,-1)=1001, (-3,+1)=0011 -> 0x93
    mode = 1'b1;
    sym(P3, M1); chk("qam_s1_valid", out_valid, 0);
    sym(M3, P1);
    chk("qam_valid", out_valid, 1);
    chk("qam_data",  out_data, 8'h93);
    chk("qam_bits",  out_bits, 4'd8);
    // Extremes: (0x8000,0)=0011, (0,0x8000)=1100 -> 0x3C
    sym(NEG, ZER);
    sym(ZER, NEG);
    chk("qam_edge_data", out_data, 8'h3C);
    chk("qam_edge_valid", out_valid, 1);
    idle();

    // Backpressure: 11 00 10 01 -> 0xC9 with out_ready low
    mode = 1'b0;
    out_ready = 1'b0;
    sym(POS, POS);
    sym(NEG, NEG);
    sym(POS, NEG);
    sym(NEG, POS);
    chk("bp_valid", out_valid, 1);
    chk("bp_data",  out_data, 8'hC9);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1'b1; I_in = POS; Q_in = POS;
    step();
    chk("bp_hold_data",  out_data, 8'hC9);
    chk("bp_hold_ready", in_ready, 0);
    step();
    chk("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", in_ready, 1);
    step();
    chk("bp_taken", out_valid, 0);
    sym(NEG, NEG);
    sym(POS, NEG);
    sym(NEG, NEG);
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_data",  out_data, 8'hC8);
    idle();

    // Flush after 00 11 10 -> 0x38, 6 bits
    sym(NEG, NEG);
    sym(POS, POS);
    sym(POS, NEG);
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", out_valid, 1);
    chk("flush_data",  out_data, 8'h38);
    chk("flush_bits",  out_bits, 4'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_empty", out_valid, 0);
    sym(NEG, NEG);
    sym(POS, NEG);
    sym(NEG, POS);
    chk("flush_s3_valid", out_valid, 0);
    sym(POS, POS);
    chk("post_flush_data", out_data, 8'h27);
    chk("post_flush_bits", out_bits, 4'd8);
    // Symbol and flush together: 11 then 01 -> 0xD0, 4 bits
    sym(POS, POS);
    flush = 1'b1;
    sym(NEG, POS);
    flush = 1'b0;
    chk("symflush_data", out_data, 8'hD0);
    chk("symflush_bits", out_bits, 4'd4);
    idle();

    // Mode change mid-word: word stays QPSK (11 00 10 01 -> 0xC9), next is 16-QAM
    mode = 1'b0;
    sym(POS, POS);
    mode = 1'b1;
    sym(M3, M3);
    chk("mch_s2_valid", out_valid, 0);
    sym(P3, M1);
    sym(M1, P1);
    chk("mch_valid", out_valid, 1);
    chk("mch_data",  out_data, 8'hC9);
    sym(P3, M1);
    chk("mch_q1_valid", out_valid, 0);
    sym(M3, P1);
    chk("mch_qam_data", out_data, 8'h93);
    chk("mch_qam_bits", out_bits, 4'd8);
    idle();
    mode = 1'b0;

    // Asynchronous reset with a pending word clears the output immediately
    out_ready = 1'b0;
    sym(POS, POS); sym(POS, POS); sym(POS, POS); sym(POS, POS);
    in_valid = 1'b0;
    chk("pend_valid", out_valid, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data",  out_data, 8'h00);
    chk("arst_bits",  out_bits, 4'd0);
    #10;
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    chk("arst_in_ready", in_ready, 1);
    chk("arst_no_out",   out_valid, 0);

    // Reset after 2 symbols: the fresh word must need all 4 of its own symbols
    sym(POS, POS);
    sym(POS, POS);
    in_valid = 1'b0;
    #3;
    reset = 1'b0;
    #10;
    reset = 1'b1;
    step();
    chk("midrst_valid", out_valid, 0);
    sym(NEG, NEG);
    sym(POS, NEG);
    sym(NEG, POS);
    chk("midrst_s3_valid", out_valid, 0);
    sym(POS, POS);
    chk("midrst_valid2", out_valid, 1);
    chk("midrst_data",   out_data, 8'h27);
    chk("midrst_bits",   out_bits, 4'd8);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qam_slicer_packer.md
# qam_slicer_packer

Parametrised successor to the QPSK demodulator: a hard-decision slicer for QPSK or Gray-coded 16-QAM symbols. It accepts streamed I/Q samples through a valid/ready handshake and packs the decided bits MSB-first into OUT_W-bit words. Words leave through a registered valid/ready output, and a flush request emits a zero-padded partial word. It sits between the channel equaliser output and the audio de-framer.

## Interface
- DATA_W, 16: width of signed two's-complement I/Q samples.
- OUT_W, 8: output word width; must be a multiple of 4 and at least 4.
- THRESH, 2: inner/outer decision boundary on |I| or |Q| for 16-QAM; unsigned and less than 2^(DATA_W-1).

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  0 = QPSK (2 bits/symbol), 1 = 16-QAM (4 bits/symbol).
- in_valid  in  1  an I/Q symbol is present.
- in_ready  out  1  the block accepts a symbol this cycle.
- I_in  in  DATA_W  signed in-phase sample.
- Q_in  in  DATA_W  signed quadrature sample.
- flush  in  1  emit the partial word; sampled only when in_ready=1.
- out_valid  out  1  out_data/out_bits hold a word.
- out_ready  in  1  the consumer takes the word.
- out_data  out  OUT_W  packed bits, first-decided bit in the MSB.
- out_bits  out  $clog2(OUT_W)+1  number of valid bits in out_data (OUT_W for a full word).

## Operation
- Symbol fire: in_valid && in_ready.
- Flush fire: flush && in_ready && bit count > 0 after any same-cycle symbol.
- in_ready = !out_valid || out_ready. The block does not consume input while an unaccepted word is pending.
- QPSK decisions: bI = ~I_in[MSB], bQ = ~Q_in[MSB]. Symbol bits are {bI, bQ}.
- 16-QAM decisions, per axis: hi = ~sign; lo = (|x| < THRESH).
  - |x| is computed in DATA_W+1 bits, so -2^(DATA_W-1) is an outer point.
  - Gray map: -3 → 00, -1 → 01, +1 → 11, +3 → 10.
  - Symbol bits are {I_hi, I_lo, Q_hi, Q_lo}.
- Packer: shift register plus bit counter cnt (0..OUT_W-1).
  - New symbol bits are appended below bits already held.
  - When cnt + bits/symbol reaches OUT_W, the word moves to the output register: out_bits=OUT_W, cnt returns to 0.
- Mode latching: mode is sampled only on a symbol fire with cnt==0 and held in mode_r for the rest of the word. Changes to mode mid-word are ignored until the next word boundary.
- Flush: the held bits move to out_data left-aligned with zero LSB padding; out_bits=cnt; cnt returns to 0.
  - Flush with cnt==0 is a no-op.
  - Flush with in_ready=0 is ignored; the caller holds flush until it is taken.
- Symbol and flush in the same cycle: the symbol bits are appended first, then the flush applies.
  - If the symbol completes the word, the flush is a no-op.
- Output register: out_valid is set on completion or flush, and cleared on out_valid && out_ready with no new word.
  - Handshake and new word in the same cycle: out_data/out_bits are replaced and out_valid stays 1.

## Timing
- Reset (asynchronous, active-low) values:
  - out_valid=0, out_data=0, out_bits=0, cnt=0, shift register=0, mode_r=0.
  - in_ready=1 one cycle after reset deasserts, because out_valid=0.
- Reset mid-word or with a pending word discards all data; no output follows.
- Latency: out_valid rises on the edge that fires the word-completing symbol or the flush, i.e. 1 cycle from that fire.
- Throughput: one symbol per cycle while out_ready=1.
  - With OUT_W=8: one word every 4 QPSK or 2 16-QAM symbols.
- out_data and out_bits are stable while out_valid=1 and out_ready=0.
- No combinational path from I_in/Q_in to any output. in_ready depends combinationally on out_ready.

## Test plan
- QPSK word, out_ready=1. Symbols (I,Q) = (0x8000,0x8000), (0x0001,0x8000), (0x8000,0x0001), (0x0001,0x0001). Required: out_data=0x27, out_bits=8, out_valid high for 1 cycle, 1 cycle after the 4th fire.
- 16-QAM word, THRESH=2. Symbols (+3,-1) then (-3,+1). Required: out_data=0x93, out_bits=8.
  - Edge case: I=0x8000 decides as 00; I=0x0000 decides as 11.
- Backpressure. Complete a word with out_ready=0 while in_valid stays 1. Required: in_ready=0; out_data held; no symbol consumed. Raising out_ready resumes input the same cycle with no bits lost or duplicated.
- Flush. After QPSK (-,-), (+,+), (+,-), pulse flush. Required: out_data=0x38, out_bits=6; the next full word starts at cnt=0.
  - Flush with cnt==0 produces no output.
- Mode change mid-word. Start QPSK, toggle mode to 1 after 1 symbol. Required: the word completes as QPSK (4 symbols); the following word is decoded as 16-QAM.
- Reset mid-operation. Assert reset (low) asynchronously mid-clock after 2 symbols. Required: out_valid, out_data, out_bits and cnt clear immediately. After release, a fresh QPSK word yields only its own bits.
